// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch PC owner and {pc, inst, pred} queue feeding decode
// Optional static BTFN predecode on imem_dout is built when INST_FETCH_BTFN_PREDICT_EN is defined.
module inst_fetch_queue #(
  parameter int IMEM_ADDR_WIDTH = 10,
  parameter int QUEUE_DEPTH     = 4,
  parameter int QUEUE_PTR_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_b,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]                imem_dout,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_inst,
  output logic [31:0]                id_pc,
  output logic                       id_pred_taken,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic [QUEUE_PTR_WIDTH:0]   queue_count
);

  localparam logic [QUEUE_PTR_WIDTH:0] LP_DEPTH = (QUEUE_PTR_WIDTH + 1)'(QUEUE_DEPTH);
  localparam logic [QUEUE_PTR_WIDTH:0] LP_ONE   = (QUEUE_PTR_WIDTH + 1)'(1);

  logic [31:0]                r_fetch_pc;
  logic [QUEUE_PTR_WIDTH-1:0] r_head;
  logic [QUEUE_PTR_WIDTH-1:0] r_tail;
  logic [QUEUE_PTR_WIDTH:0]   r_count;

  logic [31:0] r_pc_mem   [QUEUE_DEPTH];
  logic [31:0] r_inst_mem [QUEUE_DEPTH];

  logic        w_pop;
  logic        w_push;
  logic [31:0] w_next_pc;
  logic [31:0] w_redirect_pc;
  logic        w_pred;

  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_pop         = id_valid && id_ready;
  // A full queue can still accept a fetch when the head leaves in the same cycle.
  assign w_push        = !redirect && ((r_count < LP_DEPTH) || w_pop);

`ifdef INST_FETCH_BTFN_PREDICT_EN
  logic        r_pred_mem [QUEUE_DEPTH];
  logic [31:0] w_br_offset;

  assign w_pred      = (imem_dout[6:0] == 7'b1100011) && imem_dout[31];
  assign w_br_offset = {{19{imem_dout[31]}}, imem_dout[31], imem_dout[7],
                        imem_dout[30:25], imem_dout[11:8], 1'b0};
  assign w_next_pc   = w_pred ? (r_fetch_pc + w_br_offset) : (r_fetch_pc + 32'd4);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pred_mem[r_tail] <= w_pred;
    end
  end

  // Storage is not reset, so gate the flag to keep it clean while the queue is empty.
  assign id_pred_taken = id_valid && r_pred_mem[r_head];
`else
  assign w_pred        = 1'b0;
  assign w_next_pc     = r_fetch_pc + 32'd4;
  assign id_pred_taken = w_pred;
`endif

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_fetch_pc <= 32'h0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= w_next_pc;
        r_tail     <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + LP_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - LP_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]   <= r_fetch_pc;
      r_inst_mem[r_tail] <= imem_dout;
    end
  end

  assign imem_addr   = r_fetch_pc[IMEM_ADDR_WIDTH+1:2];
  assign id_valid    = (r_count != '0);
  assign queue_count = r_count;
  assign id_pc       = r_pc_mem[r_head];
  assign id_inst     = r_inst_mem[r_head];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - scoreboard bench for inst_fetch_queue
module tb_inst_fetch_queue;

  logic        clk;
  logic        reset_b;
  logic [9:0]  imem_addr;
  logic [31:0] imem_dout;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  queue_count;
  logic        plant_branch;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } exp_t;

  exp_t sb[$];

  inst_fetch_queue dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .imem_addr     (imem_addr),
    .imem_dout     (imem_dout),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .id_pred_taken (id_pred_taken),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .queue_count   (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word 2 becomes beq x0,x0,-8 when planted, else a non-branch tagged with its address.
  assign imem_dout = (plant_branch && imem_addr == 10'd2) ? 32'hFE000CE3 : {2'b00, imem_addr, 20'h00013};

  function automatic logic [31:0] exp_inst(input logic [31:0] pc, input logic planted);
    logic [9:0] w;
    w = pc[11:2];
    if (planted && w == 10'd2) return 32'hFE000CE3;
    return {2'b00, w, 20'h00013};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic planted, input logic pred);
    exp_t e;
    e.pc   = pc;
    e.inst = exp_inst(pc, planted);
    e.pred = pred;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget, input logic stream_chk);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
      if (stream_chk) begin
        chk({name, "_valid"}, {31'd0, id_valid}, 32'd1);
        chk({name, "_count"}, {29'd0, queue_count}, 32'd1);
      end
    end
    id_ready = 1'b0;
    chk({name, "_drained"}, sb.size(), 32'd0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (reset_b && id_valid && id_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual_pc=%h expected=none", id_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pop_pc", id_pc, e.pc);
        chk("pop_inst", id_inst, e.inst);
        chk("pop_pred", {31'd0, id_pred_taken}, {31'd0, e.pred});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b      = 1'b0;
    id_ready     = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    plant_branch = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_count", {29'd0, queue_count}, 32'd0);
    chk("rst_addr", {22'd0, imem_addr}, 32'd0);
    chk("rst_pred", {31'd0, id_pred_taken}, 32'd0);

    // Fill and stall
    @(negedge clk);
    reset_b = 1'b1;
    tick();
    chk("first_valid", {31'd0, id_valid}, 32'd1);
    chk("first_pc", id_pc, 32'h0);
    repeat (3) tick();
    chk("fill_count", {29'd0, queue_count}, 32'd4);
    chk("fill_pc", id_pc, 32'h0);
    chk("fill_addr", {22'd0, imem_addr}, 32'd4);
    tick();
    chk("stall_count", {29'd0, queue_count}, 32'd4);
    chk("stall_pc", id_pc, 32'h0);
    chk("stall_inst", id_inst, exp_inst(32'h0, 1'b0));
    chk("stall_addr", {22'd0, imem_addr}, 32'd4);

    // Full push+pop
    expect_entry(32'h0, 1'b0, 1'b0);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk("fullpp_pc", id_pc, 32'h4);
    chk("fullpp_count", {29'd0, queue_count}, 32'd4);
    chk("fullpp_addr", {22'd0, imem_addr}, 32'd5);
    chk("fullpp_sb", sb.size(), 32'd0);

    // Redirect while full
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    chk("redir_valid", {31'd0, id_valid}, 32'd0);
    chk("redir_count", {29'd0, queue_count}, 32'd0);
    chk("redir_addr", {22'd0, imem_addr}, 32'h40);
    tick();
    chk("redir_valid2", {31'd0, id_valid}, 32'd1);
    chk("redir_pc2", id_pc, 32'h100);
    chk("redir_count2", {29'd0, queue_count}, 32'd1);
    tick();
    tick();
    chk("pre_arst_count", {29'd0, queue_count}, 32'd3);

    // Async reset between edges
    #2;
    reset_b = 1'b0;
    #1;
    chk("arst_valid", {31'd0, id_valid}, 32'd0);
    chk("arst_count", {29'd0, queue_count}, 32'd0);
    chk("arst_addr", {22'd0, imem_addr}, 32'd0);

    // Streaming from reset release
    for (int i = 0; i < 5; i++) expect_entry(32'(i * 4), 1'b0, 1'b0);
    id_ready = 1'b1;
    @(negedge clk);
    #1;
    reset_b = 1'b1;
    drain("stream", 20, 1'b1);

    // Prediction on a planted backward branch at 0x8
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect     = 1'b0;
    plant_branch = 1'b1;
    expect_entry(32'h0, 1'b1, 1'b0);
    expect_entry(32'h4, 1'b1, 1'b0);
`ifdef INST_FETCH_BTFN_PREDICT_EN
    expect_entry(32'h8, 1'b1, 1'b1);
    expect_entry(32'h0, 1'b1, 1'b0);
`else
    expect_entry(32'h8, 1'b1, 1'b0);
    expect_entry(32'hC, 1'b1, 1'b0);
`endif
    id_ready = 1'b1;
    drain("predict", 20, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

- Fetch front-end that sits directly upstream of the decode/execute datapath.
- Owns the fetch PC and drives the combinational instruction memory address.
- Buffers fetched {pc, instruction} pairs in a small FIFO and hands them downstream over a valid/ready handshake.
- Accepts a redirect from the branch-resolution logic, which flushes the queue and restarts fetch at a new PC.

## Interface
Parameters:
- IMEM_ADDR_WIDTH, 10: word-address width of instruction memory.
- QUEUE_DEPTH, 4: FIFO entries; power of two, ≥2.
- QUEUE_PTR_WIDTH, 2: log2(QUEUE_DEPTH).

Ports:
- clk  in  1  system clock.
- reset_b  in  1  asynchronous, active-low reset.
- imem_addr  out  IMEM_ADDR_WIDTH  word address to instruction memory; equals fetch_pc[IMEM_ADDR_WIDTH+1:2].
- imem_dout  in  32  instruction memory read data; combinational, same cycle as imem_addr.
- id_valid  out  1  queue head holds a valid entry.
- id_ready  in  1  downstream accepts the head this cycle.
- id_inst  out  32  instruction at the queue head.
- id_pc  out  32  PC of the instruction at the queue head.
- id_pred_taken  out  1  head entry was fetched with a predicted-taken branch.
- redirect  in  1  flush the queue and restart fetch.
- redirect_pc  in  32  restart PC; bits [1:0] are ignored and forced to 0.
- queue_count  out  QUEUE_PTR_WIDTH+1  number of occupied entries.

## Operation
- **State:**
  - fetch_pc (32 bits).
  - Head and tail pointers (QUEUE_PTR_WIDTH bits each), which wrap modulo QUEUE_DEPTH.
  - count.
  - Per-entry {pc, inst, pred_taken}.
- **Pop:** occurs when id_valid && id_ready. id_valid = (count != 0).
- **Push condition:** (count < QUEUE_DEPTH) || pop.
  - Simultaneous push and pop while full is legal; count stays at QUEUE_DEPTH.
- **Push action:** writes {fetch_pc, imem_dout, pred} at the tail, then advances fetch_pc to next_pc.
- **No push:** fetch_pc holds, and imem_addr is therefore stable.
- **next_pc:** fetch_pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x0), unless a prediction is made (see Configuration).
- **Redirect priority:** redirect overrides everything in the cycle it is sampled:
  - count, head and tail are set to 0.
  - fetch_pc is set to {redirect_pc[31:2], 2'b00}.
  - No push occurs.
  - Any pop handshake in that cycle is still consumed by downstream; the queue is discarded regardless.
- **Head outputs:** id_inst, id_pc and id_pred_taken are driven from the head entry. They are don't-care while id_valid = 0.
- **Stability:** while id_valid && !id_ready, the head outputs must remain stable.

## Timing
- **Reset:** asynchronous; applies mid-operation at any time.
  - fetch_pc = 0, head = tail = 0, count = 0.
  - id_valid = 0, id_pred_taken = 0, queue_count = 0, imem_addr = 0.
  - Entry storage needs no reset.
- **Reset release:** the first rising edge after reset_b deasserts pushes PC 0x0. id_valid = 1 after that edge.
- **Redirect latency:**
  - Redirect sampled at edge N → id_valid = 0 after N.
  - The target instruction is pushed at N+1 → id_valid = 1 with id_pc = target after N+1.
- **Throughput:** 1 instruction/cycle sustained with id_ready held high. A pushed entry is visible at the head the cycle after the push.
- **Combinational path:** imem_dout feeds only the push data (and the predictor when enabled). No combinational path from id_ready to imem_addr.

## Configuration
- **Macro:** INST_FETCH_BTFN_PREDICT_EN.
- **Defined:** static backward-taken/forward-not-taken predecode on imem_dout.
  - Applies when opcode imem_dout[6:0] == 7'b1100011 and imem_dout[31] == 1.
  - next_pc = fetch_pc + sext({imem_dout[31], imem_dout[7], imem_dout[30:25], imem_dout[11:8], 1'b0}).
  - The pushed entry's pred_taken = 1.
  - Otherwise pred_taken = 0 and next_pc = fetch_pc + 4.
- **Undefined:** no predecode logic.
  - next_pc is always fetch_pc + 4.
  - id_pred_taken is tied to 0.

## Test plan
- **Fill and stall:** release reset with id_ready = 0 → after 4 edges queue_count = 4, id_pc = 0x0 and stable, imem_addr = 4 (fetch_pc 0x10) and held.
- **Streaming:** id_ready = 1 from reset → id_pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles, queue_count ≤ 1, no bubbles.
- **Full push+pop:** queue full, pulse id_ready for one cycle → id_pc advances 0x0 → 0x4, queue_count stays 4, fetch_pc advances by 4.
- **Redirect while full:** redirect = 1, redirect_pc = 0x103 → next cycle id_valid = 0 and queue_count = 0. The following cycle id_valid = 1 with id_pc = 0x100.
- **Prediction:** imem word at 0x8 = 0xFE000CE3 (beq x0,x0,-8):
  - With INST_FETCH_BTFN_PREDICT_EN defined → entry after 0x8 has id_pc = 0x0, and the 0x8 entry has id_pred_taken = 1.
  - Without it → next id_pc = 0xC, id_pred_taken = 0.
- **Async reset mid-stream:** assert reset_b low between edges with count = 3 → id_valid, queue_count and imem_addr go to 0 immediately, without waiting for a clock edge.
